// File: rtl/crc_ahb_mc_if.sv
// rtl/crc_ahb_mc_if.sv - AHB-Lite slave front-end for the multi-channel CRC unit
// Optional feature macro: CRC_AHB_ERR_RESP_EN adds two-cycle ERROR responses for
// unmapped decodes and a wait-state counter that times out after MAX_WAIT stalls.
// The data-phase state is resolved combinationally each cycle from the registered
// context (state_q) and the live stall sources, so a stall that clears in a cycle
// completes in that same cycle.
module crc_ahb_mc_if #(
  parameter int NUM_CH   = 4,
  parameter int MAX_WAIT = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSElx,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           bus_wr,
  output logic [1:0]            bus_size,
  output logic [CH_W-1:0]       ch_sel,
  output logic [NUM_CH-1:0]     buffer_write_en,
  output logic [NUM_CH-1:0]     crc_init_en,
  output logic [NUM_CH-1:0]     crc_idr_en,
  output logic [NUM_CH-1:0]     crc_poly_en,
  output logic [NUM_CH-1:0]     reset_chain,
  output logic [2*NUM_CH-1:0]   crc_poly_size,
  output logic [2*NUM_CH-1:0]   rev_in_type,
  output logic [NUM_CH-1:0]     rev_out_type,
  input  logic [32*NUM_CH-1:0]  crc_out,
  input  logic [32*NUM_CH-1:0]  crc_init_out,
  input  logic [32*NUM_CH-1:0]  crc_poly_out,
  input  logic [8*NUM_CH-1:0]   crc_idr_out,
  input  logic [NUM_CH-1:0]     buffer_full,
  input  logic [NUM_CH-1:0]     read_wait,
  input  logic [NUM_CH-1:0]     reset_pending
);

  localparam logic [2:0] R_DR   = 3'd0;
  localparam logic [2:0] R_IDR  = 3'd1;
  localparam logic [2:0] R_CR   = 3'd2;
  localparam logic [2:0] R_INIT = 3'd4;
  localparam logic [2:0] R_POL  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_XFER, S_WAIT, S_ERR1, S_ERR2} state_t;

  // Captured address phase
  logic [2:0]      off_q, off_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [1:0]      size_q, size_d;
  logic            wr_q, wr_d;
  logic            act_q, act_d;

  state_t          state_q, state_d, state_cur;
  logic [4:0]      cr_q [NUM_CH];
  logic [4:0]      cr_d [NUM_CH];

`ifdef CRC_AHB_ERR_RESP_EN
  logic [7:0]      wcnt_q, wcnt_d;
`endif

  // Decode results of the captured phase
  logic [NUM_CH-1:0] ch_oh;
  logic              off_ok;
  logic              mapped;
  logic              stall;
  logic              complete;
  logic              do_wr;
  logic              do_rd;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5+CH_W], HADDR[1:0], HSIZE[2], HTRANS[0]};

  assign bus_wr   = HWDATA;
  assign bus_size = size_q;
  assign ch_sel   = ch_q;

  // Address-phase capture whenever the bus is ready
  always_comb begin
    off_d  = off_q;
    ch_d   = ch_q;
    size_d = size_q;
    wr_d   = wr_q;
    act_d  = act_q;
    if (HREADY) begin
      off_d  = HADDR[4:2];
      ch_d   = HADDR[5+CH_W-1:5];
      size_d = HSIZE[1:0];
      wr_d   = HWRITE;
      act_d  = HSElx & HTRANS[1];
    end
  end

  // Register/channel decode and per-channel stall condition
  always_comb begin
    ch_oh = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) ch_oh[c] = 1'b1;
    end
    off_ok = (off_q == R_DR) || (off_q == R_IDR) || (off_q == R_CR) ||
             (off_q == R_INIT) || (off_q == R_POL);
    mapped = off_ok && (|ch_oh);
    stall  = mapped && |(ch_oh & (({NUM_CH{wr_q  && off_q == R_DR}}   & buffer_full) |
                                  ({NUM_CH{!wr_q && off_q == R_DR}}   & read_wait)   |
                                  ({NUM_CH{wr_q  && off_q == R_INIT}} & reset_pending)));
  end

  // Resolve this cycle's state and the context carried to the next cycle
  always_comb begin
    state_cur = S_IDLE;
    if (state_q == S_ERR1) begin
      state_cur = S_ERR1;
    end else if (state_q == S_ERR2) begin
      state_cur = S_ERR2;
    end else if (act_q) begin
`ifdef CRC_AHB_ERR_RESP_EN
      // Unmapped phases never stall, so the decode check only fires on the first cycle
      if ((state_q == S_IDLE && !mapped) || wcnt_q == 8'(MAX_WAIT)) state_cur = S_ERR1;
      else if (stall)                                               state_cur = S_WAIT;
      else                                                          state_cur = S_XFER;
`else
      if (stall) state_cur = S_WAIT;
      else       state_cur = S_XFER;
`endif
    end
    case (state_cur)
      S_ERR1:  state_d = S_ERR2;
      S_WAIT:  state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
`ifdef CRC_AHB_ERR_RESP_EN
    wcnt_d = (state_cur == S_WAIT) ? wcnt_q + 8'd1 : 8'd0;
`endif
  end

  // Bus response, one-hot strobes, read mux and control register update
  always_comb begin
    HREADYOUT = !(state_cur == S_WAIT || state_cur == S_ERR1);
`ifdef CRC_AHB_ERR_RESP_EN
    HRESP     = (state_cur == S_ERR1) || (state_cur == S_ERR2);
`else
    HRESP     = 1'b0;
`endif
    complete  = (state_cur == S_XFER) && mapped;
    do_wr     = complete && wr_q;
    do_rd     = complete && !wr_q;

    buffer_write_en = (do_wr && off_q == R_DR)              ? ch_oh : '0;
    crc_idr_en      = (do_wr && off_q == R_IDR)             ? ch_oh : '0;
    crc_init_en     = (do_wr && off_q == R_INIT)            ? ch_oh : '0;
    crc_poly_en     = (do_wr && off_q == R_POL)             ? ch_oh : '0;
    reset_chain     = (do_wr && off_q == R_CR && HWDATA[0]) ? ch_oh : '0;

    HRDATA = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cr_d[c] = cr_q[c];
      if (do_wr && off_q == R_CR && ch_oh[c]) cr_d[c] = HWDATA[7:3];
      if (do_rd && ch_oh[c]) begin
        case (off_q)
          R_DR:    HRDATA = crc_out[32*c +: 32];
          R_IDR:   HRDATA = {24'h0, crc_idr_out[8*c +: 8]};
          R_CR:    HRDATA = {24'h0, cr_q[c], 3'b000};
          R_INIT:  HRDATA = crc_init_out[32*c +: 32];
          R_POL:   HRDATA = crc_poly_out[32*c +: 32];
          default: HRDATA = '0;
        endcase
      end
    end
  end

  // Flatten the control register bank onto the per-channel config outputs
  always_comb begin
    crc_poly_size = '0;
    rev_in_type   = '0;
    rev_out_type  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      crc_poly_size[2*c +: 2] = cr_q[c][1:0];
      rev_in_type[2*c +: 2]   = cr_q[c][3:2];
      rev_out_type[c]         = cr_q[c][4];
    end
  end

  // State, captured phase and control register flops
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      ch_q    <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      act_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) cr_q[c] <= '0;
`ifdef CRC_AHB_ERR_RESP_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      ch_q    <= ch_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      act_q   <= act_d;
      for (int c = 0; c < NUM_CH; c++) cr_q[c] <= cr_d[c];
`ifdef CRC_AHB_ERR_RESP_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

endmodule
